operand_stack: RTL

Data stack for the tinycpu datapath, on the operand side of the ALU. It holds the evaluation stack and drives the ALU operand inputs: `a` is the top of stack, `b` is next-on-stack. It also writes the ALU result back, popping two and pushing one for binary ops, or replacing the top for unary ops. Commands come from the control unit, one per clock.

---
 rtl/operand_stack_pkg.sv | 39 +++
 rtl/operand_stack_ram.sv | 27 ++
 rtl/operand_stack.sv | 129 ++++++++++++
 3 files changed

// File: rtl/operand_stack_pkg.sv
// Shared tinycpu datapath defines: ALU function codes and operand-stack commands.
// Also provides the command decoder used by the stack.
package operand_stack_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned FN_W  = 3;

    // ALU function codes, held by control during the cycle the ALU result is consumed
    typedef enum logic [FN_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NEG  = 3'd5,
        ALU_NOT  = 3'd6,
        ALU_PASS = 3'd7
    } alu_fn_t;

    // Operand stack commands; codes 5-7 are reserved and behave as SNOP
    typedef enum logic [OP_W-1:0] {
        SNOP  = 3'd0,
        SPUSH = 3'd1,
        SPOP  = 3'd2,
        SBIN  = 3'd3,
        SUNI  = 3'd4
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic [OP_W-1:0] code);
        case (code)
            3'd1:    return SPUSH;
            3'd2:    return SPOP;
            3'd3:    return SBIN;
            3'd4:    return SUNI;
            default: return SNOP;
        endcase
    endfunction

endpackage

// File: rtl/operand_stack_ram.sv
// Spill storage below the T/N registers: one synchronous write port,
// one asynchronous read port.
module stack_ram #(
    parameter int unsigned ENTRIES = 14,
    parameter int unsigned W       = 16,
    parameter int unsigned AW      = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past the last entry only occur when the read data is ignored
    assign rdata = (32'(raddr) < ENTRIES) ? mem[raddr] : '0;

endmodule

// File: rtl/operand_stack.sv
// Evaluation stack feeding the ALU: T/N registers drive a/b directly,
// deeper entries live in the spill RAM. One command per clock.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OP_W-1:0]         op,
    input  logic [W-1:0]            din,
    input  logic [W-1:0]            s,
    output logic [W-1:0]            a,
    output logic [W-1:0]            b,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    err
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned ENTRIES = DEPTH - 2;

    stack_op_t     cmd;
    logic [W-1:0]  t_nx;
    logic [W-1:0]  n_nx;
    logic [CW-1:0] cnt_nx;
    logic          err_nx;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [W-1:0]  ram_rdata;
    logic          has_two;
    logic          has_three;
    logic          is_full;
    logic          is_empty;

    assign cmd       = decode_op(op);
    assign has_two   = (count >= CW'(2));
    assign has_three = (count >= CW'(3));
    assign is_full   = (count == CW'(DEPTH));
    assign is_empty  = (count == '0);

    // Write at sp = count-2; read at sp-1 = count-3 (only consumed when count >= 3)
    assign ram_waddr = AW'(count - CW'(2));
    assign ram_raddr = AW'(count - CW'(3));

    stack_ram #(
        .ENTRIES (ENTRIES),
        .W       (W),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (b),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Command decode: illegal commands set err and leave contents untouched
    always_comb begin
        t_nx   = a;
        n_nx   = b;
        cnt_nx = count;
        err_nx = err;
        ram_we = 1'b0;
        case (cmd)
            SPUSH: begin
                if (is_full) begin
                    err_nx = 1'b1;
                end else begin
                    ram_we = has_two;
                    n_nx   = a;
                    t_nx   = din;
                    cnt_nx = count + CW'(1);
                end
            end
            SPOP: begin
                if (is_empty) begin
                    err_nx = 1'b1;
                end else begin
                    t_nx   = b;
                    n_nx   = has_three ? ram_rdata : '0;
                    cnt_nx = count - CW'(1);
                end
            end
            SBIN: begin
                if (!has_two) begin
                    err_nx = 1'b1;
                end else begin
                    t_nx   = s;
                    n_nx   = has_three ? ram_rdata : '0;
                    cnt_nx = count - CW'(1);
                end
            end
            SUNI: begin
                if (is_empty) begin
                    err_nx = 1'b1;
                end else begin
                    t_nx = s;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a     <= '0;
            b     <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            err   <= 1'b0;
        end else begin
            a     <= t_nx;
            b     <= n_nx;
            count <= cnt_nx;
            empty <= (cnt_nx == '0);
            full  <= (cnt_nx == CW'(DEPTH));
            err   <= err_nx;
        end
    end

endmodule
